// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline register with a 2-entry skid buffer, flush, bubble
// clearing and stall/transfer counters. in_ready and out_valid come from state only.
module pipe_skid_stage #(
  parameter int DATA_W       = 32,
  parameter int CNT_W        = 16,
  parameter bit CLEAR_BUBBLE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  xfer_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   main_q, main_d;
  logic [DATA_W-1:0]   skid_q, skid_d;
  logic [CNT_W-1:0]    stall_q, stall_d;
  logic [CNT_W-1:0]    xfer_q, xfer_d;
  logic                in_hs, out_hs;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != TWO);
  assign occupancy = state_q;
  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;

  // main is zeroed on every path into EMPTY when bubbles are cleared, so it
  // can drive out_data directly.
  assign out_data  = main_q;
  assign stall_cnt = stall_q;
  assign xfer_cnt  = xfer_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    stall_d = stall_q;
    xfer_d  = xfer_q;

    if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}}))
      stall_d = stall_q + CNT_W'(1);
    if (out_hs)
      xfer_d = xfer_q + CNT_W'(1);

    if (flush) begin
      state_d = EMPTY;
      if (CLEAR_BUBBLE) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      unique case (state_q)
        EMPTY: if (in_hs) begin
          state_d = ONE;
          main_d  = in_data;
        end
        ONE: begin
          if (in_hs && out_ready) begin
            main_d = in_data;
          end else if (in_hs) begin
            state_d = TWO;
            skid_d  = in_data;
          end else if (out_ready) begin
            state_d = EMPTY;
            if (CLEAR_BUBBLE) main_d = '0;
          end
        end
        TWO: if (out_ready) begin
          state_d = ONE;
          main_d  = skid_q;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
      xfer_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
      xfer_q  <= xfer_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: three instances (default, CNT_W=2, CLEAR_BUBBLE=0)
// share stimulus and are checked against a queue-based reference model.
module tb_pipe_skid_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_data = '0;

  logic        ir_a, ov_a, ir_s, ov_s, ir_n, ov_n;
  logic [31:0] od_a, od_s, od_n;
  logic [1:0]  occ_a, occ_s, occ_n;
  logic [15:0] st_a, xf_a, st_n, xf_n;
  logic [1:0]  st_s, xf_s;

  always #5 clk = ~clk;

  pipe_skid_stage #(.DATA_W(32), .CNT_W(16), .CLEAR_BUBBLE(1'b1)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_a),
    .in_data(in_data), .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a),
    .occupancy(occ_a), .stall_cnt(st_a), .xfer_cnt(xf_a));

  pipe_skid_stage #(.DATA_W(32), .CNT_W(2), .CLEAR_BUBBLE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_s),
    .in_data(in_data), .out_valid(ov_s), .out_ready(out_ready), .out_data(od_s),
    .occupancy(occ_s), .stall_cnt(st_s), .xfer_cnt(xf_s));

  pipe_skid_stage #(.DATA_W(32), .CNT_W(16), .CLEAR_BUBBLE(1'b0)) u_nb (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_n),
    .in_data(in_data), .out_valid(ov_n), .out_ready(out_ready), .out_data(od_n),
    .occupancy(occ_n), .stall_cnt(st_n), .xfer_cnt(xf_n));

  // Reference model: a FIFO of at most two payloads plus plain counters.
  logic [31:0] q[$];
  int          stall_w, stall_s, xfer;
  logic [31:0] last_nb;
  int          n_cmp = 0, n_bad = 0;

  typedef struct {
    bit          iv;
    logic [31:0] d;
    bit          ordy;
    bit          fl;
    bit          e_v;
    logic [31:0] e_d;
    logic [1:0]  e_occ;
    bit          e_ir;
    int          e_st;
    int          e_xf;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    stall_w = 0;
    stall_s = 0;
    xfer    = 0;
    last_nb = '0;
  endtask

  task automatic model_edge();
    bit ov, ir, ohs, ihs;
    if (rst) begin
      model_reset();
    end else begin
      ov  = q.size() > 0;
      ir  = q.size() < 2;
      ohs = ov && out_ready;
      ihs = in_valid && ir;
      if (ov && !out_ready) begin
        if (stall_w < 65535) stall_w++;
        if (stall_s < 3) stall_s++;
      end
      if (ohs) xfer++;
      if (flush) q.delete();
      else begin
        if (ohs) void'(q.pop_front());
        if (ihs) q.push_back(in_data);
      end
      if (q.size() > 0) last_nb = q[0];
    end
  endtask

  task automatic check_all();
    logic [31:0] front;
    front = (q.size() > 0) ? q[0] : 32'h0;
    chk("out_valid",   32'(ov_a),  32'(q.size() > 0));
    chk("in_ready",    32'(ir_a),  32'(q.size() < 2));
    chk("occupancy",   32'(occ_a), 32'(q.size()));
    chk("out_data",    od_a,       front);
    chk("stall_cnt",   32'(st_a),  32'(stall_w % 65536));
    chk("xfer_cnt",    32'(xf_a),  32'(xfer % 65536));
    chk("sat.stall",   32'(st_s),  32'(stall_s));
    chk("sat.xfer",    32'(xf_s),  32'(xfer % 4));
    chk("nb.out_valid",32'(ov_n),  32'(q.size() > 0));
    chk("nb.out_data", od_n,       last_nb);
  endtask

  task automatic cycle(bit iv, logic [31:0] d, bit ordy, bit fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_all();
  endtask

  initial begin
    // backpressure / skid: 0x33 is offered while full and accepted later
    tbl[0] = '{1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 32'h11, 2'd1, 1'b1, 0, 0};
    tbl[1] = '{1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 32'h11, 2'd2, 1'b0, 1, 0};
    tbl[2] = '{1'b1, 32'h33, 1'b0, 1'b0, 1'b1, 32'h11, 2'd2, 1'b0, 2, 0};
    tbl[3] = '{1'b1, 32'h33, 1'b1, 1'b0, 1'b1, 32'h22, 2'd1, 1'b1, 2, 1};
    tbl[4] = '{1'b1, 32'h33, 1'b1, 1'b0, 1'b1, 32'h33, 2'd1, 1'b1, 2, 2};
    tbl[5] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 2'd0, 1'b1, 2, 3};

    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;

    // asynchronous reset mid-stream, between edges
    cycle(1'b1, 32'hA5A5A5A5, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'h12345678;
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("arst.out_valid", 32'(ov_a), 32'h0);
    chk("arst.out_data", od_a, 32'h0);
    chk("arst.in_ready", 32'(ir_a), 32'h1);
    chk("arst.occupancy", 32'(occ_a), 32'h0);
    chk("arst.stall_cnt", 32'(st_a), 32'h0);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
    rst = 1'b0;

    // streaming one per cycle
    do_reset();
    for (int i = 1; i <= 8; i++) cycle(1'b1, 32'(i), 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("stream.xfer_cnt", 32'(xf_a), 32'd8);
    chk("stream.stall_cnt", 32'(st_a), 32'd0);

    // table-driven backpressure
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
      chk("tbl.out_valid", 32'(ov_a), 32'(tbl[i].e_v));
      chk("tbl.out_data", od_a, tbl[i].e_d);
      chk("tbl.occupancy", 32'(occ_a), 32'(tbl[i].e_occ));
      chk("tbl.in_ready", 32'(ir_a), 32'(tbl[i].e_ir));
      chk("tbl.stall_cnt", 32'(st_a), 32'(tbl[i].e_st));
      chk("tbl.xfer_cnt", 32'(xf_a), 32'(tbl[i].e_xf));
    end

    // flush with a full buffer and a competing input
    do_reset();
    cycle(1'b1, 32'h44, 1'b0, 1'b0);
    cycle(1'b1, 32'h55, 1'b0, 1'b0);
    cycle(1'b1, 32'h66, 1'b0, 1'b1);
    chk("flush.out_valid", 32'(ov_a), 32'h0);
    chk("flush.out_data", od_a, 32'h0);
    chk("flush.in_ready", 32'(ir_a), 32'h1);
    chk("flush.nb_hold", od_n, 32'h44);
    repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // counter saturation and wrap on the narrow instance
    do_reset();
    cycle(1'b1, 32'h9, 1'b0, 1'b0);
    repeat (6) cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("sat.stall_is_3", 32'(st_s), 32'd3);
    chk("sat.wide_stall", 32'(st_a), 32'd6);
    repeat (5) cycle(1'b1, $urandom, 1'b1, 1'b0);
    chk("sat.xfer_wrap", 32'(xf_s), 32'd1);

    // no bubble clearing: payload stays visible after drain
    do_reset();
    cycle(1'b1, 32'h77, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("nb.idle_valid", 32'(ov_n), 32'h0);
    chk("nb.idle_data", od_n, 32'h77);

    // randomized traffic
    do_reset();
    repeat (400)
      cycle(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 19) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
